// File: rtl/mc_control_fsm.sv
// Multicycle RISC-V control unit: Moore sequencer plus ALU decoder.
// Optional MC_BNE_EN: BEQ state also resolves bne via funct3[0].
module mc_control_fsm #(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic [2:0] ALUControl,
  output logic       Illegal
);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ,
    S_JAL
  } state_t;

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic       wdone;
  logic [1:0] aluop;
  logic       pcw, irw, mw, rw, ill;
  logic       brtaken;

  logic op_ld, op_st, op_r, op_i, op_br, op_jal;

  assign op_ld  = (op == 7'b0000011);
  assign op_st  = (op == 7'b0100011);
  assign op_r   = (op == 7'b0110011);
  assign op_i   = (op == 7'b0010011);
  assign op_br  = (op == 7'b1100011);
  assign op_jal = (op == 7'b1101111);

  assign wdone = (cnt == 4'(MEM_WAIT));

`ifdef MC_BNE_EN
  assign brtaken = funct3[0] ? ~Zero : Zero;
`else
  assign brtaken = Zero;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    pcw       = 1'b0;
    irw       = 1'b0;
    mw        = 1'b0;
    rw        = 1'b0;
    ill       = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    aluop     = 2'b00;
    unique case (state)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (wdone) begin
          irw     = 1'b1;
          pcw     = 1'b1;
          state_n = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        state_n = S_FETCH;
        unique case (1'b1)
          op_ld, op_st: state_n = S_MEMADR;
          op_r:         state_n = S_EXECR;
          op_i:         state_n = S_EXECI;
          op_br:        state_n = S_BEQ;
          op_jal:       state_n = S_JAL;
          default:      ill     = 1'b1;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_n = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (wdone) state_n = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        rw        = 1'b1;
        state_n   = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        if (wdone) begin
          mw      = 1'b1;
          state_n = S_FETCH;
        end
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        aluop   = 2'b10;
        state_n = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        aluop   = 2'b10;
        state_n = S_ALUWB;
      end
      S_ALUWB: begin
        rw      = 1'b1;
        state_n = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA = 2'b10;
        aluop   = 2'b01;
        pcw     = brtaken;
        state_n = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        pcw     = 1'b1;
        state_n = S_ALUWB;
      end
      default: state_n = S_FETCH;
    endcase
    // counter restarts on every state entry
    cnt_n = (state_n == state) ? cnt + 4'd1 : 4'd0;
  end

  always_comb begin
    ImmSrc = 2'b00;
    unique case (1'b1)
      op_st:   ImmSrc = 2'b01;
      op_br:   ImmSrc = 2'b10;
      op_jal:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  always_comb begin
    ALUControl = 3'b000;
    unique case (aluop)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        unique case (funct3)
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b001:  ALUControl = 3'b110;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  // write strobes are suppressed while reset is held
  assign PCWrite  = pcw & ~reset;
  assign IRWrite  = irw & ~reset;
  assign MemWrite = mw  & ~reset;
  assign RegWrite = rw  & ~reset;
  assign Illegal  = ill & ~reset;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized bench for mc_control_fsm against a phase-list model.
// Instance 0 uses MEM_WAIT=0, instance 1 uses MEM_WAIT=2.
module tb_mc_control_fsm;

  localparam logic [16:0] MASK = 17'b1_0_1_1_00_00_00_00_1_000_1;

  logic       clk = 1'b0;
  logic       reset_v [2];
  logic [6:0] op_v    [2];
  logic [2:0] f3_v    [2];
  logic       f7_v    [2];
  logic       z_v     [2];

  logic       pcw [2];
  logic       adr [2];
  logic       mw  [2];
  logic       irw [2];
  logic [1:0] res [2];
  logic [1:0] sa  [2];
  logic [1:0] sb  [2];
  logic [1:0] imm [2];
  logic       rw  [2];
  logic [2:0] alu [2];
  logic       ill [2];

  logic [16:0] obs0, obs1;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  mc_control_fsm #(.MEM_WAIT(0)) dut0 (
    .clk(clk), .reset(reset_v[0]), .op(op_v[0]), .funct3(f3_v[0]),
    .funct7b5(f7_v[0]), .Zero(z_v[0]), .PCWrite(pcw[0]), .AdrSrc(adr[0]),
    .MemWrite(mw[0]), .IRWrite(irw[0]), .ResultSrc(res[0]),
    .ALUSrcA(sa[0]), .ALUSrcB(sb[0]), .ImmSrc(imm[0]), .RegWrite(rw[0]),
    .ALUControl(alu[0]), .Illegal(ill[0])
  );

  mc_control_fsm #(.MEM_WAIT(2)) dut1 (
    .clk(clk), .reset(reset_v[1]), .op(op_v[1]), .funct3(f3_v[1]),
    .funct7b5(f7_v[1]), .Zero(z_v[1]), .PCWrite(pcw[1]), .AdrSrc(adr[1]),
    .MemWrite(mw[1]), .IRWrite(irw[1]), .ResultSrc(res[1]),
    .ALUSrcA(sa[1]), .ALUSrcB(sb[1]), .ImmSrc(imm[1]), .RegWrite(rw[1]),
    .ALUControl(alu[1]), .Illegal(ill[1])
  );

  assign obs0 = {pcw[0], adr[0], mw[0], irw[0], res[0], sa[0], sb[0],
                 imm[0], rw[0], alu[0], ill[0]};
  assign obs1 = {pcw[1], adr[1], mw[1], irw[1], res[1], sa[1], sb[1],
                 imm[1], rw[1], alu[1], ill[1]};

  function automatic logic [16:0] obs(int k);
    return (k == 0) ? obs0 : obs1;
  endfunction

  function automatic int mwait(int k);
    return (k == 0) ? 0 : 2;
  endfunction

  task automatic chk(string tag, logic [16:0] got, logic [16:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %b want %b", tag, got, exp);
    end
  endtask

  function automatic bit legal(logic [6:0] o);
    return o inside {7'b0000011, 7'b0100011, 7'b0110011,
                     7'b0010011, 7'b1100011, 7'b1101111};
  endfunction

  function automatic logic [2:0] aluctl(logic [1:0] aop, logic [6:0] o,
                                        logic [2:0] f3, logic f7);
    if (aop == 2'd0) return 3'b000;
    if (aop == 2'd1) return 3'b001;
    case (f3)
      3'b000:  return (o[5] && f7) ? 3'b001 : 3'b000;
      3'b001:  return 3'b110;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [16:0] expv(string ph, bit fin, logic [6:0] o,
                                       logic [2:0] f3, logic f7, logic z);
    logic p = 0, a = 0, m = 0, i = 0, r = 0, il = 0;
    logic [1:0] rs = 0, ca = 0, cb = 0, im = 0, aop = 0;
    case (o)
      7'b0100011: im = 2'b01;
      7'b1100011: im = 2'b10;
      7'b1101111: im = 2'b11;
      default:    im = 2'b00;
    endcase
    case (ph)
      "FETCH":    begin cb = 2; rs = 2; i = fin; p = fin; end
      "DECODE":   begin ca = 1; cb = 1; il = !legal(o); end
      "MEMADR":   begin ca = 2; cb = 1; end
      "MEMREAD":  a = 1;
      "MEMWB":    begin rs = 1; r = 1; end
      "MEMWRITE": begin a = 1; m = fin; end
      "EXECR":    begin ca = 2; aop = 2; end
      "EXECI":    begin ca = 2; cb = 1; aop = 2; end
      "ALUWB":    r = 1;
      "BEQ": begin
        ca = 2; aop = 1;
`ifdef MC_BNE_EN
        p = f3[0] ? !z : z;
`else
        p = z;
`endif
      end
      "JAL":      begin ca = 1; cb = 2; p = 1; end
      default:    ;
    endcase
    return {p, a, m, i, rs, ca, cb, im, r, aluctl(aop, o, f3, f7), il};
  endfunction

  // stop < 0 runs the whole instruction, else only the first stop cycles
  task automatic run_instr(int k, logic [6:0] o, logic [2:0] f3,
                           logic f7, logic z, int stop);
    string ph[$];
    bit    fin[$];
    int    n;
    for (int w = 0; w <= mwait(k); w++) begin
      ph.push_back("FETCH"); fin.push_back(w == mwait(k));
    end
    if (legal(o)) begin
      ph.push_back("DECODE"); fin.push_back(1);
      case (o)
        7'b0000011: begin
          ph.push_back("MEMADR"); fin.push_back(1);
          for (int w = 0; w <= mwait(k); w++) begin
            ph.push_back("MEMREAD"); fin.push_back(w == mwait(k));
          end
          ph.push_back("MEMWB"); fin.push_back(1);
        end
        7'b0100011: begin
          ph.push_back("MEMADR"); fin.push_back(1);
          for (int w = 0; w <= mwait(k); w++) begin
            ph.push_back("MEMWRITE"); fin.push_back(w == mwait(k));
          end
        end
        7'b0110011: begin
          ph.push_back("EXECR"); ph.push_back("ALUWB");
          fin.push_back(1); fin.push_back(1);
        end
        7'b0010011: begin
          ph.push_back("EXECI"); ph.push_back("ALUWB");
          fin.push_back(1); fin.push_back(1);
        end
        7'b1100011: begin ph.push_back("BEQ"); fin.push_back(1); end
        default: begin
          ph.push_back("JAL"); ph.push_back("ALUWB");
          fin.push_back(1); fin.push_back(1);
        end
      endcase
    end else begin
      ph.push_back("DECODE"); fin.push_back(1);
    end
    n = (stop < 0) ? ph.size() : stop;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      reset_v[k] = 1'b0;
      op_v[k] = o; f3_v[k] = f3; f7_v[k] = f7; z_v[k] = z;
      #1;
      chk($sformatf("%s%0d_k%0d", ph[c], c, k), obs(k),
          expv(ph[c], fin[c], o, f3, f7, z));
    end
  endtask

  task automatic apply_reset(int k, int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      reset_v[k] = 1'b1;
      #1;
      chk($sformatf("rst_strobe_k%0d", k), obs(k) & MASK, 17'd0);
      if (c > 0)
        chk($sformatf("rst_state_k%0d", k), obs(k),
            expv("FETCH", 1'b1, op_v[k], f3_v[k], f7_v[k], z_v[k]) & ~MASK);
    end
  endtask

  task automatic rand_instr(int k);
    logic [6:0] o;
    int sel = $urandom_range(0, 7);
    case (sel)
      0: o = 7'b0000011;
      1: o = 7'b0100011;
      2: o = 7'b0110011;
      3: o = 7'b0010011;
      4: o = 7'b1100011;
      5: o = 7'b1101111;
      default: o = 7'($urandom);
    endcase
    run_instr(k, o, 3'($urandom), 1'($urandom), 1'($urandom), -1);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      reset_v[k] = 1'b1; op_v[k] = '0; f3_v[k] = '0;
      f7_v[k] = 1'b0; z_v[k] = 1'b0;
    end

    apply_reset(0, 3);
    run_instr(0, 7'b0000011, 3'b010, 1'b0, 1'b0, -1);
    run_instr(0, 7'b0110011, 3'b000, 1'b1, 1'b0, -1);
    run_instr(0, 7'b0110011, 3'b001, 1'b0, 1'b0, -1);
    run_instr(0, 7'b0110011, 3'b010, 1'b0, 1'b0, -1);
    run_instr(0, 7'b0010011, 3'b000, 1'b1, 1'b0, -1);
    run_instr(0, 7'b1100011, 3'b000, 1'b0, 1'b1, -1);
    run_instr(0, 7'b1100011, 3'b000, 1'b0, 1'b0, -1);
    run_instr(0, 7'b1100011, 3'b001, 1'b0, 1'b0, -1);
    run_instr(0, 7'b1101111, 3'b000, 1'b0, 1'b0, -1);
    run_instr(0, 7'b1111111, 3'b000, 1'b0, 1'b0, -1);
    run_instr(0, 7'b0100011, 3'b010, 1'b0, 1'b0, -1);
    for (int t = 0; t < 200; t++) rand_instr(0);

    apply_reset(1, 2);
    run_instr(1, 7'b0100011, 3'b010, 1'b0, 1'b0, -1);
    run_instr(1, 7'b0000011, 3'b010, 1'b0, 1'b0, -1);
    run_instr(1, 7'b0000011, 3'b010, 1'b0, 1'b0, 6);
    apply_reset(1, 2);
    run_instr(1, 7'b0000011, 3'b010, 1'b0, 1'b0, -1);
    for (int t = 0; t < 100; t++) rand_instr(1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
